// File: rtl/ccff_stream_loader.sv
// Configuration-chain driver: serializes host bitstream words MSB-first onto
// ccff_head, gates the chain shift, and optionally checks ccff_tail on a verify pass.
module ccff_stream_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 20,
  parameter int CNT_W  = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              verify,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int WB_W = $clog2(WORD_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [LEN_W-1:0] WORD_LEN  = LEN_W'(WORD_W);
  localparam logic [WB_W-1:0]  WORD_BITS = WB_W'(WORD_W);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              verify_q;
  logic [LEN_W-1:0]  bits_left;
  logic [WB_W-1:0]   word_bits;
  logic [WORD_W-1:0] sreg;
  logic              accept;
  logic              tail_miss;

  // Outputs decode straight from the state register, so all are 0 in IDLE.
  assign word_ready   = (state == S_FETCH);
  assign chain_clk_en = (state == S_SHIFT);
  assign busy         = (state == S_FETCH) || (state == S_SHIFT);
  assign done         = (state == S_FINISH);
  assign ccff_head    = chain_clk_en & sreg[WORD_W-1];
  assign accept       = word_ready & word_valid;
  assign tail_miss    = chain_clk_en & verify_q & (ccff_tail != sreg[WORD_W-1]);

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (chain_len == '0) ? S_FINISH : S_FETCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (accept) begin
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_SHIFT: begin
        if (bits_left == LEN_W'(1)) begin
          state_nxt = S_FINISH;
        end else if (word_bits == WB_W'(1)) begin
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, shift datapath and verify bookkeeping.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state        <= S_IDLE;
      verify_q     <= 1'b0;
      bits_left    <= '0;
      word_bits    <= '0;
      sreg         <= '0;
      error        <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            verify_q     <= verify;
            bits_left    <= chain_len;
            error        <= 1'b0;
            mismatch_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (accept) begin
            sreg      <= word_data;
            // Short final word: only its top bits_left bits will be shifted.
            word_bits <= (bits_left >= WORD_LEN) ? WORD_BITS : WB_W'(bits_left);
          end
        end
        S_SHIFT: begin
          sreg      <= {sreg[WORD_W-2:0], 1'b0};
          word_bits <= word_bits - WB_W'(1);
          bits_left <= bits_left - LEN_W'(1);
          if (tail_miss) begin
            error <= 1'b1;
            if (mismatch_cnt != '1) begin
              mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
